// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - MEM-stage load/store unit with big-endian data-bus FSM
// Optional LSU_ALIGN_CHECK_EN enables halfword/word alignment exceptions.
`ifndef EXC_CODE_WIDTH
`define EXC_CODE_WIDTH 5
`endif
`ifndef EC_NONE
`define EC_NONE 5'h1f
`endif
`ifndef EC_ADEL
`define EC_ADEL 5'h04
`endif
`ifndef EC_ADES
`define EC_ADES 5'h05
`endif
`ifndef STOP
`define STOP 1'b1
`endif
`ifndef NOSTOP
`define NOSTOP 1'b0
`endif
`ifndef EXE_LB_OP
`define EXE_LB_OP  8'b11100000
`define EXE_LH_OP  8'b11100001
`define EXE_LW_OP  8'b11100011
`define EXE_LBU_OP 8'b11100100
`define EXE_LHU_OP 8'b11100101
`define EXE_SB_OP  8'b11101000
`define EXE_SH_OP  8'b11101001
`define EXE_SW_OP  8'b11101011
`endif

module mem_lsu (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 mem_aluop,
  input  logic [31:0]                mem_mem_addr,
  input  logic [31:0]                mem_reg2,
  input  logic [4:0]                 mem_wd,
  input  logic                       mem_wreg,
  input  logic [31:0]                mem_wdata,
  input  logic [`EXC_CODE_WIDTH-1:0] exc_code_i,
  input  logic                       flush,
  input  logic [5:0]                 stall,
  output logic                       stallreq_o,
  output logic [4:0]                 wb_wd,
  output logic                       wb_wreg,
  output logic [31:0]                wb_wdata,
  output logic [`EXC_CODE_WIDTH-1:0] exc_code_o,
  output logic [31:0]                exc_badvaddr_o,
  output logic                       dbus_req,
  output logic                       dbus_we,
  output logic [3:0]                 dbus_sel,
  output logic [31:0]                dbus_addr,
  output logic [31:0]                dbus_wdata,
  input  logic                       dbus_ack,
  input  logic [31:0]                dbus_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE, DRAIN} state_t;
  state_t state, state_nx;

  logic        is_load, is_store, is_byte, is_half, is_word, is_signed;
  logic        align_fault, up_exc, go;
  logic [1:0]  off;
  logic [3:0]  sel_nx;
  logic [31:0] wdata_nx, load_data, result;
  logic        unused_stall;

  assign unused_stall = &{stall[5], stall[3:0], 1'b0};
  assign off = mem_mem_addr[1:0];

  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_byte   = 1'b0;
    is_half   = 1'b0;
    is_word   = 1'b0;
    is_signed = 1'b0;
    case (mem_aluop)
      `EXE_LB_OP:  begin is_load  = 1'b1; is_byte = 1'b1; is_signed = 1'b1; end
      `EXE_LBU_OP: begin is_load  = 1'b1; is_byte = 1'b1; end
      `EXE_LH_OP:  begin is_load  = 1'b1; is_half = 1'b1; is_signed = 1'b1; end
      `EXE_LHU_OP: begin is_load  = 1'b1; is_half = 1'b1; end
      `EXE_LW_OP:  begin is_load  = 1'b1; is_word = 1'b1; end
      `EXE_SB_OP:  begin is_store = 1'b1; is_byte = 1'b1; end
      `EXE_SH_OP:  begin is_store = 1'b1; is_half = 1'b1; end
      `EXE_SW_OP:  begin is_store = 1'b1; is_word = 1'b1; end
      default: ;
    endcase
  end

`ifdef LSU_ALIGN_CHECK_EN
  assign align_fault = (is_half && off[0]) || (is_word && (off != 2'b00));
`else
  assign align_fault = 1'b0;
`endif

  assign up_exc = (exc_code_i != `EC_NONE);
  assign go     = (is_load || is_store) && !up_exc && !align_fault && !flush;

  always_comb begin
    exc_code_o     = `EC_NONE;
    exc_badvaddr_o = 32'h0;
    if (up_exc) begin
      exc_code_o = exc_code_i;
    end else if (align_fault) begin
      exc_code_o     = is_load ? `EC_ADEL : `EC_ADES;
      exc_badvaddr_o = mem_mem_addr;
    end
  end

  // Big-endian lanes: offset 0 is the most significant byte.
  always_comb begin
    sel_nx   = 4'b1111;
    wdata_nx = mem_reg2;
    if (is_byte) begin
      sel_nx   = 4'b1000 >> off;
      wdata_nx = {4{mem_reg2[7:0]}};
    end else if (is_half) begin
      sel_nx   = off[1] ? 4'b0011 : 4'b1100;
      wdata_nx = {2{mem_reg2[15:0]}};
    end
  end

  always_comb begin
    load_data = dbus_rdata;
    if (is_byte) begin
      case (off)
        2'd0:    load_data = {{24{is_signed & dbus_rdata[31]}}, dbus_rdata[31:24]};
        2'd1:    load_data = {{24{is_signed & dbus_rdata[23]}}, dbus_rdata[23:16]};
        2'd2:    load_data = {{24{is_signed & dbus_rdata[15]}}, dbus_rdata[15:8]};
        default: load_data = {{24{is_signed & dbus_rdata[7]}},  dbus_rdata[7:0]};
      endcase
    end else if (is_half) begin
      load_data = off[1] ? {{16{is_signed & dbus_rdata[15]}}, dbus_rdata[15:0]}
                         : {{16{is_signed & dbus_rdata[31]}}, dbus_rdata[31:16]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    stallreq_o = 1'b0;
    case (state)
      IDLE: begin
        stallreq_o = go;
        if (go) state_nx = WAIT;
      end
      WAIT: begin
        stallreq_o = 1'b1;
        if (flush) state_nx = dbus_ack ? IDLE : DRAIN;
        else if (dbus_ack) state_nx = DONE;
      end
      DONE: begin
        if (flush || stall[4] == `NOSTOP) state_nx = IDLE;
      end
      DRAIN: begin
        stallreq_o = go;
        if (dbus_ack) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_sel   <= 4'h0;
      dbus_addr  <= 32'h0;
      dbus_wdata <= 32'h0;
      result     <= 32'h0;
    end else begin
      case (state)
        IDLE: if (go) begin
          dbus_req   <= 1'b1;
          dbus_we    <= is_store;
          dbus_sel   <= sel_nx;
          dbus_addr  <= {mem_mem_addr[31:2], 2'b00};
          dbus_wdata <= wdata_nx;
        end
        WAIT: if (dbus_ack) begin
          dbus_req <= 1'b0;
          if (!flush) result <= load_data;
        end
        DRAIN: if (dbus_ack) dbus_req <= 1'b0;
        default: ;
      endcase
    end
  end

  assign wb_wd    = mem_wd;
  assign wb_wreg  = mem_wreg && !up_exc && !align_fault && (state != DRAIN);
  assign wb_wdata = is_load ? result : mem_wdata;

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - directed self-checking bench for mem_lsu
module tb_mem_lsu;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_LB  = 8'b11100000;
  localparam logic [7:0] OP_LH  = 8'b11100001;
  localparam logic [7:0] OP_LW  = 8'b11100011;
  localparam logic [7:0] OP_LBU = 8'b11100100;
  localparam logic [7:0] OP_SB  = 8'b11101000;
  localparam logic [7:0] OP_SH  = 8'b11101001;
  localparam logic [4:0] ECN    = 5'h1f;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  mem_aluop;
  logic [31:0] mem_mem_addr, mem_reg2, mem_wdata;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [4:0]  exc_code_i;
  logic        flush;
  logic [5:0]  stall;
  logic        stallreq_o;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic [4:0]  exc_code_o;
  logic [31:0] exc_badvaddr_o;
  logic        dbus_req, dbus_we;
  logic [3:0]  dbus_sel;
  logic [31:0] dbus_addr, dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;

  int checks = 0;
  int errors = 0;

  mem_lsu dut (
    .clk(clk), .rst(rst), .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr),
    .mem_reg2(mem_reg2), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .exc_code_i(exc_code_i), .flush(flush), .stall(stall), .stallreq_o(stallreq_o),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata), .exc_code_o(exc_code_o),
    .exc_badvaddr_o(exc_badvaddr_o), .dbus_req(dbus_req), .dbus_we(dbus_we),
    .dbus_sel(dbus_sel), .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
    .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic edge_step;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  task automatic set_op(input logic [7:0] op, input logic [31:0] addr, input logic wreg);
    mem_aluop    = op;
    mem_mem_addr = addr;
    mem_wreg     = wreg;
  endtask

  // Issue in c0, ack in c1, DONE in c2, then back to a NOP.
  task automatic access(input string tag, input logic [7:0] op, input logic [31:0] addr,
                        input logic [31:0] reg2, input logic [31:0] rdata,
                        input logic [3:0] exp_sel, input logic [31:0] exp_addr,
                        input logic exp_we, input logic [31:0] exp_bus_wdata,
                        input logic [31:0] exp_wb);
    edge_step;
    set_op(op, addr, 1'b1);
    mem_reg2  = reg2;
    mem_wdata = 32'h55;
    sample;
    check({tag, "_stallreq_c0"}, stallreq_o, 1);
    edge_step;
    dbus_ack   = 1'b1;
    dbus_rdata = rdata;
    sample;
    check({tag, "_req"}, dbus_req, 1);
    check({tag, "_sel"}, dbus_sel, exp_sel);
    check({tag, "_addr"}, dbus_addr, exp_addr);
    check({tag, "_we"}, dbus_we, exp_we);
    if (exp_we) check({tag, "_bus_wdata"}, dbus_wdata, exp_bus_wdata);
    edge_step;
    dbus_ack   = 1'b0;
    dbus_rdata = 32'h0;
    sample;
    check({tag, "_wb_wdata"}, wb_wdata, exp_wb);
    check({tag, "_stallreq_done"}, stallreq_o, 0);
    edge_step;
    set_op(OP_NOP, 32'h0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; stall = 6'b0; dbus_ack = 1'b0; dbus_rdata = 32'h0;
    mem_reg2 = 32'h0; mem_wdata = 32'h0; mem_wd = 5'd3; exc_code_i = ECN;
    set_op(OP_NOP, 32'h0, 1'b0);
    edge_step;
    sample;
    check("rst_req", dbus_req, 0);
    check("rst_sel", dbus_sel, 0);
    check("rst_addr", dbus_addr, 0);
    check("rst_stallreq", stallreq_o, 0);
    edge_step;
    rst = 1'b0;

    // LW with ack in c3 and a one-cycle MEM/WB hold in DONE.
    edge_step;
    set_op(OP_LW, 32'h100, 1'b1);
    sample;
    check("lw_c0_stallreq", stallreq_o, 1);
    check("lw_c0_req", dbus_req, 0);
    edge_step; sample;
    check("lw_c1_req", dbus_req, 1);
    check("lw_c1_addr", dbus_addr, 32'h100);
    check("lw_c1_sel", dbus_sel, 4'hf);
    edge_step; sample;
    check("lw_c2_req", dbus_req, 1);
    check("lw_c2_stallreq", stallreq_o, 1);
    edge_step;
    dbus_ack = 1'b1; dbus_rdata = 32'hDEADBEEF;
    sample;
    check("lw_c3_req", dbus_req, 1);
    check("lw_c3_stallreq", stallreq_o, 1);
    edge_step;
    dbus_ack = 1'b0; dbus_rdata = 32'h0; stall = 6'b010000;
    sample;
    check("lw_c4_req", dbus_req, 0);
    check("lw_c4_stallreq", stallreq_o, 0);
    check("lw_c4_wdata", wb_wdata, 32'hDEADBEEF);
    check("lw_c4_wreg", wb_wreg, 1);
    edge_step;
    stall = 6'b0;
    sample;
    check("lw_hold_wdata", wb_wdata, 32'hDEADBEEF);
    check("lw_hold_stallreq", stallreq_o, 0);
    edge_step;
    set_op(OP_NOP, 32'h0, 1'b0);
    sample;
    check("lw_idle_stallreq", stallreq_o, 0);

    access("lb",  OP_LB,  32'h103, 32'h0, 32'h11223380, 4'b0001, 32'h100, 1'b0, 32'h0, 32'hFFFFFF80);
    access("lbu", OP_LBU, 32'h103, 32'h0, 32'h11223380, 4'b0001, 32'h100, 1'b0, 32'h0, 32'h00000080);
    access("lh",  OP_LH,  32'h100, 32'h0, 32'h87651234, 4'b1100, 32'h100, 1'b0, 32'h0, 32'hFFFF8765);
    access("sh",  OP_SH,  32'h202, 32'h0000ABCD, 32'h0, 4'b0011, 32'h200, 1'b1, 32'hABCDABCD, 32'h55);
    access("sb",  OP_SB,  32'h101, 32'h12345678, 32'h0, 4'b0100, 32'h100, 1'b1, 32'h78787878, 32'h55);

`ifdef LSU_ALIGN_CHECK_EN
    edge_step;
    set_op(OP_LW, 32'h101, 1'b1);
    sample;
    check("al_stallreq", stallreq_o, 0);
    check("al_exc", exc_code_o, 5'h04);
    check("al_badv", exc_badvaddr_o, 32'h101);
    check("al_wreg", wb_wreg, 0);
    edge_step; sample;
    check("al_req", dbus_req, 0);
    set_op(OP_NOP, 32'h0, 1'b0);
`else
    access("lw_unal", OP_LW, 32'h101, 32'h0, 32'hA5A5A5A5, 4'hf, 32'h100, 1'b0, 32'h0, 32'hA5A5A5A5);
`endif

    // Upstream exception passes through without a bus access.
    edge_step;
    set_op(OP_LW, 32'h100, 1'b1);
    exc_code_i = 5'h0a;
    sample;
    check("ux_stallreq", stallreq_o, 0);
    check("ux_exc", exc_code_o, 5'h0a);
    check("ux_badv", exc_badvaddr_o, 0);
    check("ux_wreg", wb_wreg, 0);
    edge_step; sample;
    check("ux_req", dbus_req, 0);
    exc_code_i = ECN;
    set_op(OP_NOP, 32'h0, 1'b0);

    // Flush in c2 of WAIT, ack in c4, next load enters in c3.
    edge_step;
    set_op(OP_LW, 32'h300, 1'b1);
    edge_step;
    edge_step;
    flush = 1'b1;
    sample;
    check("fl_c2_req", dbus_req, 1);
    edge_step;
    flush = 1'b0;
    set_op(OP_LW, 32'h400, 1'b1);
    sample;
    check("fl_c3_req", dbus_req, 1);
    check("fl_c3_stallreq", stallreq_o, 1);
    check("fl_c3_wreg", wb_wreg, 0);
    edge_step;
    dbus_ack = 1'b1; dbus_rdata = 32'h1111;
    sample;
    check("fl_c4_req", dbus_req, 1);
    check("fl_c4_wreg", wb_wreg, 0);
    edge_step;
    dbus_ack = 1'b0; dbus_rdata = 32'h0;
    sample;
    check("fl_c5_req", dbus_req, 0);
    check("fl_c5_stallreq", stallreq_o, 1);
    edge_step; sample;
    check("fl_c6_addr", dbus_addr, 32'h400);
    check("fl_c6_stallreq", stallreq_o, 1);
    edge_step;
    dbus_ack = 1'b1; dbus_rdata = 32'hCAFEF00D;
    edge_step;
    dbus_ack = 1'b0; dbus_rdata = 32'h0;
    sample;
    check("fl_done_wdata", wb_wdata, 32'hCAFEF00D);
    check("fl_done_wreg", wb_wreg, 1);
    check("fl_done_stallreq", stallreq_o, 0);
    edge_step;
    set_op(OP_NOP, 32'h0, 1'b0);

    // Flush coinciding with ack in WAIT goes straight to IDLE.
    edge_step;
    set_op(OP_LW, 32'h500, 1'b1);
    edge_step;
    flush = 1'b1; dbus_ack = 1'b1; dbus_rdata = 32'h2222;
    edge_step;
    flush = 1'b0; dbus_ack = 1'b0; dbus_rdata = 32'h0;
    set_op(OP_NOP, 32'h0, 1'b0);
    sample;
    check("fa_req", dbus_req, 0);
    check("fa_stallreq", stallreq_o, 0);

    // Reset while WAIT abandons the transaction.
    edge_step;
    set_op(OP_SH, 32'h602, 1'b0);
    mem_reg2 = 32'h1234;
    edge_step;
    rst = 1'b1;
    set_op(OP_NOP, 32'h0, 1'b0);
    sample;
    check("rw_req_before", dbus_req, 1);
    edge_step;
    rst = 1'b0;
    sample;
    check("rw_req", dbus_req, 0);
    check("rw_stallreq", stallreq_o, 0);
    check("rw_we", dbus_we, 0);
    check("rw_sel", dbus_sel, 0);
    check("rw_addr", dbus_addr, 0);
    check("rw_wdata", dbus_wdata, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
